l2_tcdm_port_adapter: RTL

- Per-master adapter sitting directly upstream of one input port of the L2 subsystem TCDM interconnect (uDMA channel or AXI bridge lane).
- Converts a valid/ready request/response master protocol into TCDM req/gnt/r_valid: 1-cycle response latency, write responses enabled.
- Buffers responses so a master applying rsp backpressure never loses data.
- Rejects out-of-window addresses locally with an error response, keeping all responses in order.

---
 rtl/l2_port_pkg.sv | 13 +
 rtl/fifo_v3.sv | 69 ++++++
 rtl/l2_tcdm_port_adapter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/l2_port_pkg.sv
// Shared types for the L2 TCDM port adapter: the response-buffer entry and
// bus widths.
package l2_port_pkg;

    localparam int unsigned L2_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH = 4;

    typedef struct packed {
        logic [L2_DATA_WIDTH-1:0] rdata;
        logic                     err;
    } rsp_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through, occupancy output and
// flush. Storage is cleared on reset so the head reads as zero when empty.
module fifo_v3 #(
    parameter bit           FALL_THROUGH = 1'b0,
    parameter int unsigned  DEPTH        = 4,
    parameter type          dtype        = logic,
    localparam int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o,
    input  dtype             data_i,
    input  logic             push_i,
    output dtype             data_o,
    input  logic             pop_i
);

    dtype              mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stored_empty;
    logic              bypass;
    logic              do_push;
    logic              do_pop;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    assign stored_empty = (cnt_q == '0);
    // In fall-through mode a push into an empty FIFO that is popped at once never lands in storage
    assign bypass       = FALL_THROUGH && stored_empty && push_i && pop_i;
    assign full_o       = (cnt_q == CNT_W'(DEPTH));
    assign empty_o      = stored_empty && !(FALL_THROUGH && push_i);
    assign usage_o      = cnt_q;
    assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem_q[rd_q];
    assign do_push      = push_i && !full_o && !bypass;
    assign do_pop       = pop_i && !stored_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wrap_inc(wr_q);
            end
            if (do_pop) rd_q <= wrap_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/l2_tcdm_port_adapter.sv
// Valid/ready master to TCDM req/gnt/r_valid adapter for one L2 interconnect
// port, with an in-order response buffer and local out-of-window error replies.
module l2_tcdm_port_adapter
    import l2_port_pkg::*;
#(
    parameter logic [31:0]              ADDR_BASE  = 32'h1C00_0000,
    parameter logic [31:0]              ADDR_SIZE  = 32'h0008_0000,
    parameter int unsigned              FIFO_DEPTH = 4,
    parameter logic [L2_DATA_WIDTH-1:0] ERR_RDATA  = 32'hBADC_AB1E
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    input  logic                     req_we_i,
    input  logic [L2_DATA_WIDTH-1:0] req_wdata_i,
    input  logic [TCDM_BE_WIDTH-1:0] req_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [L2_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [15:0]              err_count_o,
    output logic                     tcdm_req_o,
    output logic [31:0]              tcdm_add_o,
    output logic                     tcdm_wen_o,
    output logic [L2_DATA_WIDTH-1:0] tcdm_wdata_o,
    output logic [TCDM_BE_WIDTH-1:0] tcdm_be_o,
    input  logic                     tcdm_gnt_i,
    input  logic                     tcdm_r_valid_i,
    input  logic [L2_DATA_WIDTH-1:0] tcdm_r_rdata_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occ;
    logic             in_range;
    logic             credit;
    logic             accept;
    logic             pop;
    logic             empty;
    logic             full;
    logic             inflight_q;
    logic             err_q;
    logic [15:0]      err_count_q;

    assign in_range = (req_addr_i >= ADDR_BASE) && ((req_addr_i - ADDR_BASE) < ADDR_SIZE);

    // Every accepted request reserves a buffer slot until its response is popped.
    // Reset is folded in so the handshake outputs read zero while rst_ni is low.
    assign occ    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit = rst_ni && (occ < OCC_W'(FIFO_DEPTH));

    assign tcdm_req_o   = req_valid_i && in_range && credit;
    assign req_ready_o  = credit && (in_range ? tcdm_gnt_i : 1'b1);
    assign accept       = req_valid_i && req_ready_o;
    assign tcdm_add_o   = {req_addr_i[31:2], 2'b00};
    assign tcdm_wen_o   = ~req_we_i;
    assign tcdm_wdata_o = req_wdata_i;
    assign tcdm_be_o    = req_be_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) err_q <= ~in_range;
        end
    end

    assign push_entry.rdata = err_q ? ERR_RDATA : tcdm_r_rdata_i;
    assign push_entry.err   = err_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (FIFO_DEPTH),
        .dtype        (rsp_entry_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (fifo_count),
        .data_i  (push_entry),
        .push_i  (inflight_q),
        .data_o  (head),
        .pop_i   (pop)
    );

    assign rsp_valid_o = ~empty;
    assign rsp_rdata_o = head.rdata;
    assign rsp_err_o   = head.err;
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_q <= '0;
        end else if (pop && head.err && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count_o = err_count_q;

`ifndef SYNTHESIS
    logic post_rst_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) post_rst_q <= 1'b1;
        else         post_rst_q <= 1'b0;
    end

    a_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !post_rst_q |-> (tcdm_r_valid_i == (inflight_q && !err_q)));

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
            (req_valid_i && $stable({req_addr_i, req_we_i, req_wdata_i, req_be_i})));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        inflight_q |-> !full);
`endif

endmodule
